trap_sequencer: RTL and testbench

//  Interrupt/trap controller sequencing the fetch stage on keyboard, game-tick and stack-overflow events.

---
 rtl/trap_pkg.sv | 28 ++
 rtl/trap_sequencer_if.sv | 33 +++
 rtl/trap_pending.sv | 61 ++++++
 rtl/trap_sequencer.sv | 138 +++++++++++++
 tb/tb_trap_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer: FSM state and trap-source
// encodings, ISR entry addresses and the register numbers used by injected loads.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SAVE   = 3'd2,
    KIDR   = 3'd3,
    BRANCH = 3'd4,
    ISR    = 3'd5
  } state_e;

  // Source value doubles as the bit index into the pending vector
  typedef enum logic [1:0] {
    SRC_KBD  = 2'd0,
    SRC_TICK = 2'd1,
    SRC_SOV  = 2'd2
  } src_e;

  localparam logic [31:0] ISR_ADDR_KBD  = 32'h0000_03FE;
  localparam logic [31:0] ISR_ADDR_TICK = 32'h0000_03FD;
  localparam logic [31:0] ISR_ADDR_SOV  = 32'h0000_03FF;

  localparam int EPC_REG = 30;
  localparam int IDR_REG = 28;

endpackage

// File: rtl/trap_sequencer_if.sv
// Fetch-stage side of the trap sequencer: stall/rti/PC coming in, NOP-injection,
// load-injection and ISR-branch controls plus saved EPC going out.
interface trap_sequencer_if;
  logic        stall;
  logic        rti;
  logic [31:0] PC_curr;
  logic        keyboard_hazard;
  logic        game_tick_hazard;
  logic        stack_overflow_hazard;
  logic        ld_epc;
  logic        ld_idr;
  logic        branch_to_keyboard_ISR;
  logic        branch_to_gametick_ISR;
  logic        branch_to_stackoverflow_ISR;
  logic [31:0] EPC;
  logic        in_isr;

  modport master (
    input  stall, rti, PC_curr,
    output keyboard_hazard, game_tick_hazard, stack_overflow_hazard,
           ld_epc, ld_idr,
           branch_to_keyboard_ISR, branch_to_gametick_ISR, branch_to_stackoverflow_ISR,
           EPC, in_isr
  );

  modport slave (
    output stall, rti, PC_curr,
    input  keyboard_hazard, game_tick_hazard, stack_overflow_hazard,
           ld_epc, ld_idr,
           branch_to_keyboard_ISR, branch_to_gametick_ISR, branch_to_stackoverflow_ISR,
           EPC, in_isr
  );
endinterface

// File: rtl/trap_pending.sv
// Pending-request latches for the three trap sources, sticky keyboard overrun flag
// and fixed-priority winner selection (overflow > tick > keyboard).
module trap_pending
  import trap_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic kbd_valid,
  input  logic game_tick,
  input  logic stack_overflow,
  input  logic clr,
  input  src_e clr_src,
  output logic req,
  output src_e src,
  output logic kbd_pend,
  output logic kbd_overrun
);

  logic [2:0] event_vec;
  logic [2:0] pend_reg;
  logic       overrun_reg;

  assign event_vec = {stack_overflow, game_tick, kbd_valid};

  // A fresh pulse wins over the clear so an event landing on the take cycle is kept
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pend
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pend_reg[gi] <= 1'b0;
        end else if (event_vec[gi]) begin
          pend_reg[gi] <= 1'b1;
        end else if (clr && (clr_src == src_e'(2'(gi)))) begin
          pend_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_reg <= 1'b0;
    end else if (kbd_valid && pend_reg[0]) begin
      overrun_reg <= 1'b1;
    end
  end

  always_comb begin
    src = SRC_KBD;
    if (pend_reg[2]) begin
      src = SRC_SOV;
    end else if (pend_reg[1]) begin
      src = SRC_TICK;
    end
  end

  assign req         = |pend_reg;
  assign kbd_pend    = pend_reg[0];
  assign kbd_overrun = overrun_reg;

endmodule

// File: rtl/trap_sequencer.sv
// Trap sequencer FSM: drains the pipeline, injects EPC/IDR loads and branches to the ISR.
// Define TRAP_CNT_EN to add saturating per-source trap counters.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    kbd_valid,
  input  logic [7:0]              kbd_data,
  input  logic                    game_tick,
  input  logic                    stack_overflow,
  input  logic                    int_en,
  trap_sequencer_if.master        fetch,
  output logic [7:0]              idr_data,
  output logic                    kbd_overrun
`ifdef TRAP_CNT_EN
  ,
  output logic [15:0]             trap_cnt_kbd,
  output logic [15:0]             trap_cnt_tick,
  output logic [15:0]             trap_cnt_sov
`endif
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_DRAIN  = DRAIN;
  localparam logic [2:0] S_SAVE   = SAVE;
  localparam logic [2:0] S_KIDR   = KIDR;
  localparam logic [2:0] S_BRANCH = BRANCH;
  localparam logic [2:0] S_ISR    = ISR;

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  logic [2:0]  state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  src_e        src_reg;
  logic [31:0] epc_reg;
  logic [7:0]  idr_reg;
  logic        req;
  src_e        win_src;
  logic        kbd_pend;
  logic        take;
  logic        seq_active;

  trap_pending u_pending (
    .clk            (clk),
    .rst_n          (rst_n),
    .kbd_valid      (kbd_valid),
    .game_tick      (game_tick),
    .stack_overflow (stack_overflow),
    .clr            (take),
    .clr_src        (win_src),
    .req            (req),
    .src            (win_src),
    .kbd_pend       (kbd_pend),
    .kbd_overrun    (kbd_overrun)
  );

  assign take = (state_reg == S_IDLE) && req && int_en && !fetch.stall;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!fetch.stall) begin
      case (state_reg)
        S_IDLE:   if (take) begin
                    state_next = S_DRAIN;
                    cnt_next   = 3'd0;
                  end
        S_DRAIN:  if (cnt_reg == DRAIN_LAST) state_next = S_SAVE;
                  else                       cnt_next   = cnt_reg + 3'd1;
        S_SAVE:   state_next = (src_reg == SRC_KBD) ? S_KIDR : S_BRANCH;
        S_KIDR:   state_next = S_BRANCH;
        S_BRANCH: state_next = S_ISR;
        S_ISR:    if (fetch.rti) state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 3'd0;
      src_reg   <= SRC_KBD;
      epc_reg   <= 32'd0;
      idr_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (take) begin
        epc_reg <= fetch.PC_curr;
        src_reg <= win_src;
      end
      // An unconsumed byte is preserved; the newer one only raises overrun
      if (kbd_valid && !kbd_pend) begin
        idr_reg <= kbd_data;
      end
    end
  end

  assign seq_active = state_reg inside {S_DRAIN, S_SAVE, S_KIDR, S_BRANCH};

  assign fetch.keyboard_hazard             = seq_active && (src_reg == SRC_KBD);
  assign fetch.game_tick_hazard            = seq_active && (src_reg == SRC_TICK);
  assign fetch.stack_overflow_hazard       = seq_active && (src_reg == SRC_SOV);
  assign fetch.ld_epc                      = (state_reg == S_SAVE);
  assign fetch.ld_idr                      = (state_reg == S_KIDR);
  assign fetch.branch_to_keyboard_ISR      = (state_reg == S_BRANCH) && (src_reg == SRC_KBD);
  assign fetch.branch_to_gametick_ISR      = (state_reg == S_BRANCH) && (src_reg == SRC_TICK);
  assign fetch.branch_to_stackoverflow_ISR = (state_reg == S_BRANCH) && (src_reg == SRC_SOV);
  assign fetch.in_isr                      = (state_reg == S_ISR);
  assign fetch.EPC                         = epc_reg;
  assign idr_data                          = idr_reg;

`ifdef TRAP_CNT_EN
  logic [15:0] trap_cnt_reg [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          trap_cnt_reg[gi] <= 16'd0;
        end else if ((state_reg == S_BRANCH) && !fetch.stall &&
                     (src_reg == src_e'(2'(gi))) && (trap_cnt_reg[gi] != 16'hFFFF)) begin
          trap_cnt_reg[gi] <= trap_cnt_reg[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign trap_cnt_kbd  = trap_cnt_reg[0];
  assign trap_cnt_tick = trap_cnt_reg[1];
  assign trap_cnt_sov  = trap_cnt_reg[2];
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: per-cycle comparison against a phase-offset
// model of each trap, plus directed scenarios with hand-computed expectations.
module tb_trap_sequencer;
  import trap_pkg::*;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kbd_valid;
  logic [7:0] kbd_data;
  logic       game_tick;
  logic       stack_overflow;
  logic       int_en;
  logic [7:0] idr_data;
  logic       kbd_overrun;
`ifdef TRAP_CNT_EN
  logic [15:0] trap_cnt_kbd, trap_cnt_tick, trap_cnt_sov;
`endif

  trap_sequencer_if fif();

  always #5 clk = ~clk;

  trap_sequencer #(.DRAIN_CYCLES(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .kbd_valid      (kbd_valid),
    .kbd_data       (kbd_data),
    .game_tick      (game_tick),
    .stack_overflow (stack_overflow),
    .int_en         (int_en),
    .fetch          (fif),
    .idr_data       (idr_data),
    .kbd_overrun    (kbd_overrun)
`ifdef TRAP_CNT_EN
    ,
    .trap_cnt_kbd   (trap_cnt_kbd),
    .trap_cnt_tick  (trap_cnt_tick),
    .trap_cnt_sov   (trap_cnt_sov)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a trap is described by its source and how many unstalled cycles it has run
  logic [2:0]  m_pend;
  logic        m_overrun, m_busy, m_isr;
  logic        m_ready = 1'b0;
  logic [7:0]  m_idr;
  logic [31:0] m_epc;
  int          m_src, m_k;
  int          m_cnt [3];

  function automatic int seq_len(input int s);
    return (s == 0) ? D + 3 : D + 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [2:0] ev;
    logic [2:0] old;
    int w;
    if (!rst_n) begin
      m_pend = '0; m_overrun = 0; m_idr = 0; m_busy = 0; m_isr = 0;
      m_src = 0; m_k = 0; m_epc = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_ready = 1'b1;
      return;
    end
    ev  = {stack_overflow, game_tick, kbd_valid};
    old = m_pend;
    if (!fif.stall) begin
      if (m_busy) begin
        if (m_k == seq_len(m_src) - 1) begin
          m_busy = 0;
          m_isr  = 1;
          if (m_cnt[m_src] != 65535) m_cnt[m_src]++;
        end else begin
          m_k++;
        end
      end else if (m_isr) begin
        if (fif.rti) m_isr = 0;
      end else if (old != 3'b000 && int_en) begin
        w = old[2] ? 2 : (old[1] ? 1 : 0);
        m_busy = 1; m_k = 0; m_src = w; m_epc = fif.PC_curr;
        m_pend[w] = 1'b0;
      end
    end
    if (kbd_valid) begin
      if (old[0]) m_overrun = 1;
      else        m_idr = kbd_data;
    end
    m_pend = m_pend | ev;
  endtask

  task automatic compare_all();
    check("keyboard_hazard",       fif.keyboard_hazard,       m_busy && m_src == 0);
    check("game_tick_hazard",      fif.game_tick_hazard,      m_busy && m_src == 1);
    check("stack_overflow_hazard", fif.stack_overflow_hazard, m_busy && m_src == 2);
    check("ld_epc",                fif.ld_epc,                m_busy && m_k == D);
    check("ld_idr",                fif.ld_idr,                m_busy && m_src == 0 && m_k == D + 1);
    check("branch_kbd",  fif.branch_to_keyboard_ISR,      m_busy && m_src == 0 && m_k == seq_len(0) - 1);
    check("branch_tick", fif.branch_to_gametick_ISR,      m_busy && m_src == 1 && m_k == seq_len(1) - 1);
    check("branch_sov",  fif.branch_to_stackoverflow_ISR, m_busy && m_src == 2 && m_k == seq_len(2) - 1);
    check("in_isr",      fif.in_isr,      m_isr);
    check("EPC",         fif.EPC,         m_epc);
    check("idr_data",    idr_data,        m_idr);
    check("kbd_overrun", kbd_overrun,     m_overrun);
`ifdef TRAP_CNT_EN
    check("trap_cnt_kbd",  trap_cnt_kbd,  m_cnt[0]);
    check("trap_cnt_tick", trap_cnt_tick, m_cnt[1]);
    check("trap_cnt_sov",  trap_cnt_sov,  m_cnt[2]);
`endif
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_ready) compare_all();
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_rti();
    fif.rti = 1'b1;
    cyc(1);
    fif.rti = 1'b0;
  endtask

  task automatic wait_isr(input string name);
    for (int i = 0; i < 30 && !fif.in_isr; i++) cyc(1);
    check(name, fif.in_isr, 1);
  endtask

  initial begin
    int hz_cnt, epc_cnt;
    logic [31:0] epc_seen;
    logic [7:0]  idr_seen;
    logic        brk_seen;

    rst_n = 0; kbd_valid = 0; kbd_data = 0; game_tick = 0; stack_overflow = 0;
    int_en = 0; fif.stall = 0; fif.rti = 0; fif.PC_curr = 0;
    cyc(3);
    check("rst_in_isr", fif.in_isr, 0);
    check("rst_EPC", fif.EPC, 0);
    check("rst_idr", idr_data, 0);
    rst_n = 1;
    int_en = 1;
    cyc(1);

    // Keyboard trap: latency, drain length, EPC and IDR capture
    fif.PC_curr = 32'h120; kbd_valid = 1; kbd_data = 8'h41;
    cyc(1);
    kbd_valid = 0;
    check("kbd_latency_pre", fif.keyboard_hazard, 0);
    cyc(1);
    fif.PC_curr = 32'h124;
    check("kbd_latency_hz", fif.keyboard_hazard, 1);
    hz_cnt = 1; epc_seen = 0; idr_seen = 0; brk_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (fif.keyboard_hazard) hz_cnt++;
      if (fif.ld_epc) epc_seen = fif.EPC;
      if (fif.ld_idr) idr_seen = idr_data;
      if (fif.branch_to_keyboard_ISR) brk_seen = 1;
    end
    check("kbd_hazard_cycles", hz_cnt, D + 3);
    check("kbd_epc", epc_seen, 32'h120);
    check("kbd_idr", idr_seen, 8'h41);
    check("kbd_branch", brk_seen, 1);
    check("kbd_in_isr", fif.in_isr, 1);
    do_rti();
    $display("kbd trap: EPC=%0h idr=%0h", epc_seen, idr_seen);

    // Overrun and int_en gating with a tick pending
    int_en = 0;
    kbd_valid = 1; kbd_data = 8'h43; cyc(1);
    kbd_data = 8'h42; cyc(1);
    kbd_valid = 0; game_tick = 1; cyc(1);
    game_tick = 0;
    cyc(4);
    check("overrun_idr", idr_data, 8'h43);
    check("overrun_flag", kbd_overrun, 1);
    check("gated_no_hz", fif.game_tick_hazard, 0);
    int_en = 1;
    cyc(1);
    check("ungated_tick_first", fif.game_tick_hazard, 1);
    wait_isr("tick_isr");
    do_rti();
    wait_isr("kbd2_isr");
    do_rti();
    $display("gated tick then pending kbd serviced, idr=%0h", idr_data);

    // Simultaneous tick + overflow; int_en dropped mid-sequence
    game_tick = 1; stack_overflow = 1; cyc(1);
    game_tick = 0; stack_overflow = 0;
    cyc(1);
    check("prio_sov_hz", fif.stack_overflow_hazard, 1);
    check("prio_tick_idle", fif.game_tick_hazard, 0);
    int_en = 0;
    wait_isr("sov_isr");
    int_en = 1;
    do_rti();
    wait_isr("tick_after_sov_isr");
    // Event coincident with rti is serviced after one idle cycle
    fif.rti = 1; stack_overflow = 1; cyc(1);
    fif.rti = 0; stack_overflow = 0;
    check("rti_evt_idle", fif.stack_overflow_hazard, 0);
    cyc(1);
    check("rti_evt_hz", fif.stack_overflow_hazard, 1);
    wait_isr("rti_evt_isr");
    do_rti();
    $display("priority and rti-coincident overflow serviced");

    // Stall during SAVE holds ld_epc
    fif.PC_curr = 32'h200; kbd_valid = 1; kbd_data = 8'h5A; cyc(1);
    kbd_valid = 0;
    for (int i = 0; i < 20 && !fif.ld_epc; i++) cyc(1);
    check("ld_epc_reached", fif.ld_epc, 1);
    epc_cnt = 1;
    fif.stall = 1; cyc(1);
    epc_cnt += int'(fif.ld_epc); cyc(1);
    epc_cnt += int'(fif.ld_epc);
    fif.stall = 0; cyc(1);
    check("stall_ld_idr_next", fif.ld_idr, 1);
    epc_cnt += int'(fif.ld_epc);
    check("stall_ld_epc_cycles", epc_cnt, 3);
    wait_isr("stall_isr");
    do_rti();
    $display("stalled SAVE: ld_epc held %0d cycles", epc_cnt);

    // Reset mid-DRAIN
    game_tick = 1; cyc(1);
    game_tick = 0; cyc(1);
    check("pre_rst_drain", fif.game_tick_hazard, 1);
    rst_n = 0; cyc(1);
    rst_n = 1;
    check("rst_mid_hz", fif.game_tick_hazard, 0);
    check("rst_mid_EPC", fif.EPC, 0);
`ifdef TRAP_CNT_EN
    check("rst_mid_cnt_kbd", trap_cnt_kbd, 0);
`endif
    cyc(5);
    check("rst_pend_lost", fif.game_tick_hazard, 0);
    $display("reset during drain returned to idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
